// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin sharing of one combinational 32-bit ULA between two requesters,
// with a tagged response buffer. Define ULA_ARB_GRANT_COUNT_EN to add per-requester grant counters.
module ula_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic [WIDTH-1:0]  ula_a,
  output logic [WIDTH-1:0]  ula_b,
  output logic [CTRL_W-1:0] ula_ctrl,
  input  logic [WIDTH-1:0]  ula_result,
  input  logic              ula_zero,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [WIDTH-1:0]  resp_data,
  output logic              resp_zero,
`ifdef ULA_ARB_GRANT_COUNT_EN
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1,
`endif
  output logic [1:0]        state_dbg,
  output logic              busy
);

  // Handshakes: a request transfers in the cycle where req_valid[i] && req_ready[i];
  // a response transfers in the cycle where resp_valid[i] && resp_ready[i].
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;
  logic   ptr;
  logic   id;
  logic   win_id;
  logic   hs;
  logic   resp_take;

  always_comb begin
    win_id = ptr;
    if (!req_valid[ptr]) win_id = ~ptr;
    hs = (state == IDLE) && (req_valid != 2'b00);
    req_ready = 2'b00;
    if (hs) req_ready[win_id] = 1'b1;
    resp_valid = 2'b00;
    if (state == RESP) resp_valid[id] = 1'b1;
    resp_take = (state == RESP) && resp_ready[id];
    state_next = state;
    case (state)
      IDLE:    if (hs) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (resp_take) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The ula_* outputs double as the operand latches, so they hold their value outside EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      id        <= 1'b0;
      ula_a     <= '0;
      ula_b     <= '0;
      ula_ctrl  <= '0;
      resp_data <= '0;
      resp_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (hs) begin
        id <= win_id;
        if (win_id) begin
          ula_a    <= req1_a;
          ula_b    <= req1_b;
          ula_ctrl <= req1_ctrl;
        end else begin
          ula_a    <= req0_a;
          ula_b    <= req0_b;
          ula_ctrl <= req0_ctrl;
        end
      end
      if (state == EXEC) begin
        resp_data <= ula_result;
        resp_zero <= ula_zero;
      end
      if (resp_take) ptr <= ~id;
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

`ifdef ULA_ARB_GRANT_COUNT_EN
  // Clear has priority over an increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (hs) begin
      if (win_id) grant_cnt1 <= grant_cnt1 + 1'b1;
      else        grant_cnt0 <= grant_cnt0 + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule
